// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch sequencer of the 16-bit RISC
//   core: the sequencer state encoding, default reset PC and halt opcode, and
//   the position of the opcode field inside an instruction word.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Fetch sequencer states.
    //   ST_IDLE  : no request outstanding, waiting for run (and not halted)
    //   ST_REQ   : read request to instruction memory in flight at pc
    //   ST_VALID : instruction held in the IR, waiting for decode to accept it
    //   ST_FLUSH : a redirected request is draining; its data is thrown away
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    // Default PC after reset and default opcode that stops fetching.
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [3:0]  DEFAULT_HALT_OP  = 4'hF;

    // Opcode field of an instruction word: inst[15:12].
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Extract the opcode field from a 16-bit instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Sequences instruction fetch for the 16-bit RISC core. Owns the PC, runs
//   the instruction-memory read handshake and hands each fetched word to the
//   instruction register with a one-cycle synchronous load enable (ir_load)
//   instead of gating the IR clock. Branch redirects from execute override any
//   fetch in progress.
//
// Ports
//   CLK           in   core clock, all state changes on posedge
//   RST           in   synchronous active-high reset
//   run           in   level, 1 = fetching allowed
//   mem_req       out  read request to instruction memory
//   mem_addr      out  read address (pc, or the abandoned address while flushing)
//   mem_ack       in   read data valid this cycle
//   mem_rdata     in   read data, used only when mem_ack = 1
//   ir_load       out  one-cycle IR load enable
//   ir_data       out  registered instruction word for the IR
//   inst_valid    out  ir_data holds an instruction not yet accepted
//   inst_ready    in   decode accepts ir_data while inst_valid = 1
//   branch_taken  in   one-cycle redirect pulse
//   branch_target in   new PC, used when branch_taken = 1
//   pc            out  address of the next instruction to fetch
//   halted        out  a halt instruction has been accepted
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [OPC_W-1:0]  HALT_OP  = DEFAULT_HALT_OP
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_load,
    output logic [DATA_W-1:0] ir_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              mem_req_reg;
    logic              ir_load_reg;
    logic [DATA_W-1:0] ir_data_reg;
    logic              inst_valid_reg;
    logic              halted_reg;

    // Address of a request abandoned by a branch. The memory still owes us a
    // response for it, so the address stays on the bus until that ack arrives
    // even though pc already points at the branch target.
    logic [ADDR_W-1:0] flush_addr_reg;

    // Opcode of the held instruction, used to detect a halt on accept.
    logic [OPC_W-1:0]  held_opcode;
    assign held_opcode = opcode_of(16'(ir_data_reg));

    // -------------------------------------------------------------------------
    // Sequencer
    //   mem_req is registered alongside the state so that it is exactly 1 in
    //   REQ and FLUSH and 0 in IDLE and VALID: every state assignment below is
    //   paired with the matching mem_req value.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            mem_req_reg    <= 1'b0;
            ir_load_reg    <= 1'b0;
            ir_data_reg    <= '0;
            inst_valid_reg <= 1'b0;
            halted_reg     <= 1'b0;
            flush_addr_reg <= RESET_PC;
        end else begin
            // IR load enable is a single-cycle pulse; it is only re-armed by an
            // accepted memory response in REQ.
            ir_load_reg <= 1'b0;

            if (branch_taken) begin
                // A redirect beats both a memory ack and a decode accept: the
                // held instruction is dropped and a halt is cancelled.
                pc_reg         <= branch_target;
                inst_valid_reg <= 1'b0;
                halted_reg     <= 1'b0;

                case (state_reg)
                    ST_REQ: begin
                        if (mem_ack) begin
                            // Request completed this very cycle: its data is
                            // stale, so just start over at the target.
                            state_reg   <= ST_REQ;
                            mem_req_reg <= 1'b1;
                        end else begin
                            // Request still outstanding: drain it first.
                            state_reg      <= ST_FLUSH;
                            mem_req_reg    <= 1'b1;
                            flush_addr_reg <= pc_reg;
                        end
                    end
                    ST_FLUSH: begin
                        // Already draining; keep the original abandoned
                        // address and just pick up the newer target in pc.
                        state_reg   <= ST_FLUSH;
                        mem_req_reg <= 1'b1;
                    end
                    default: begin
                        // IDLE or VALID: nothing in flight, fetch the target.
                        state_reg   <= ST_REQ;
                        mem_req_reg <= 1'b1;
                    end
                endcase
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (run && !halted_reg) begin
                            state_reg   <= ST_REQ;
                            mem_req_reg <= 1'b1;
                        end
                    end

                    ST_REQ: begin
                        // The request always completes, whatever run does.
                        if (mem_ack) begin
                            ir_data_reg    <= mem_rdata;
                            pc_reg         <= pc_reg + ADDR_W'(1);
                            ir_load_reg    <= 1'b1;
                            inst_valid_reg <= 1'b1;
                            state_reg      <= ST_VALID;
                            mem_req_reg    <= 1'b0;
                        end
                    end

                    ST_VALID: begin
                        // Held instruction is never dropped because of run=0;
                        // run only decides whether to fetch again after accept.
                        if (inst_ready) begin
                            inst_valid_reg <= 1'b0;
                            if (held_opcode == HALT_OP) begin
                                halted_reg  <= 1'b1;
                                state_reg   <= ST_IDLE;
                                mem_req_reg <= 1'b0;
                            end else if (run) begin
                                state_reg   <= ST_REQ;
                                mem_req_reg <= 1'b1;
                            end else begin
                                state_reg   <= ST_IDLE;
                                mem_req_reg <= 1'b0;
                            end
                        end
                    end

                    ST_FLUSH: begin
                        // Returned word belongs to the abandoned address and
                        // is discarded; the request line stays up and moves
                        // straight on to the redirected pc.
                        if (mem_ack) begin
                            state_reg   <= ST_REQ;
                            mem_req_reg <= 1'b1;
                        end
                    end

                    default: begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req    = mem_req_reg;
    assign mem_addr   = (state_reg == ST_FLUSH) ? flush_addr_reg : pc_reg;
    assign ir_load    = ir_load_reg;
    assign ir_data    = ir_data_reg;
    assign inst_valid = inst_valid_reg;
    assign pc         = pc_reg;
    assign halted     = halted_reg;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. A second instance with RESET_PC=FFFF
//   shares all inputs to exercise PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        run;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        inst_ready;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic        mem_req,    w_mem_req;
    logic [15:0] mem_addr,   w_mem_addr;
    logic        ir_load,    w_ir_load;
    logic [15:0] ir_data,    w_ir_data;
    logic        inst_valid, w_inst_valid;
    logic [15:0] pc,         w_pc;
    logic        halted,     w_halted;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK(CLK), .RST(RST), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_load(ir_load), .ir_data(ir_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .halted(halted)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .CLK(CLK), .RST(RST), .run(run),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_load(w_ir_load), .ir_data(w_ir_data),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(w_pc), .halted(w_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".mem_req"},    32'(mem_req),    32'h0);
        check({tag, ".ir_load"},    32'(ir_load),    32'h0);
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'h0);
        check({tag, ".ir_data"},    32'(ir_data),    32'h0);
        check({tag, ".halted"},     32'(halted),     32'h0);
        check({tag, ".pc"},         32'(pc),         32'h0);
    endtask

    initial begin
        RST = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        inst_ready = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        #1;
        tick(); tick();
        RST = 1'b0;
        check_reset("rst");
        check("rst.wrap_pc", 32'(w_pc), 32'hFFFF);

        // ---- 1: first fetch, ack one cycle after request ----
        run = 1'b1;
        tick();
        check("t1.mem_req",  32'(mem_req),  32'h1);
        check("t1.mem_addr", 32'(mem_addr), 32'h0000);
        check("t1.wrap_addr", 32'(w_mem_addr), 32'hFFFF);
        tick();
        check("t1.wait_req", 32'(mem_req),  32'h1);
        check("t1.no_load",  32'(ir_load),  32'h0);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        check("t1.ir_load",    32'(ir_load),    32'h1);
        check("t1.ir_data",    32'(ir_data),    32'h1234);
        check("t1.inst_valid", 32'(inst_valid), 32'h1);
        check("t1.pc",         32'(pc),         32'h0001);
        check("t1.req_off",    32'(mem_req),    32'h0);
        // ---- 5: wrap instance, FFFF -> 0000 ----
        check("t5.wrap_pc",    32'(w_pc),       32'h0000);
        check("t5.wrap_load",  32'(w_ir_load),  32'h1);

        // ---- 2: decode stalls for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2.stall%0d.ir_data", i), 32'(ir_data),    32'h1234);
            check($sformatf("t2.stall%0d.mem_req", i), 32'(mem_req),    32'h0);
            check($sformatf("t2.stall%0d.valid", i),   32'(inst_valid), 32'h1);
            check($sformatf("t2.stall%0d.ir_load", i), 32'(ir_load),    32'h0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2.valid_clr", 32'(inst_valid), 32'h0);
        check("t2.mem_req",   32'(mem_req),    32'h1);
        check("t2.mem_addr",  32'(mem_addr),   32'h0001);

        // ---- 3: branch during REQ without ack -> FLUSH ----
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("t3.flush_req", 32'(mem_req), 32'h1);
        check("t3.pc",        32'(pc),      32'h0040);
        tick();
        tick();
        check("t3.flush_hold", 32'(mem_req), 32'h1);
        check("t3.flush_noval", 32'(inst_valid), 32'h0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        check("t3.no_load",  32'(ir_load),    32'h0);
        check("t3.no_valid", 32'(inst_valid), 32'h0);
        check("t3.ir_kept",  32'(ir_data),    32'h1234);
        check("t3.mem_req",  32'(mem_req),    32'h1);
        check("t3.mem_addr", 32'(mem_addr),   32'h0040);

        // ---- 4: halt instruction, then branch restarts ----
        mem_ack = 1'b1; mem_rdata = 16'hF000;
        tick();
        mem_ack = 1'b0;
        check("t4.ir_data", 32'(ir_data), 32'hF000);
        check("t4.pc",      32'(pc),      32'h0041);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t4.halted",  32'(halted),  32'h1);
        check("t4.req_off", 32'(mem_req), 32'h0);
        tick();
        check("t4.park_halted", 32'(halted),  32'h1);
        check("t4.park_req",    32'(mem_req), 32'h0);
        branch_taken = 1'b1; branch_target = 16'h0010;
        tick();
        branch_taken = 1'b0;
        check("t4.unhalt",   32'(halted),   32'h0);
        check("t4.mem_req",  32'(mem_req),  32'h1);
        check("t4.mem_addr", 32'(mem_addr), 32'h0010);

        // ---- run=0: outstanding fetch completes, parks after accept ----
        run = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        tick();
        mem_ack = 1'b0;
        check("r0.ir_data", 32'(ir_data),    32'h2222);
        check("r0.valid",   32'(inst_valid), 32'h1);
        tick();
        check("r0.held",    32'(inst_valid), 32'h1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("r0.idle_req", 32'(mem_req), 32'h0);
        check("r0.pc",       32'(pc),      32'h0011);
        tick();
        check("r0.stay_idle", 32'(mem_req), 32'h0);

        // ---- 6a: reset while in VALID ----
        run = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        tick();
        mem_ack = 1'b0;
        check("t6a.valid", 32'(inst_valid), 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset("t6a");

        // ---- branch in REQ with same-cycle ack drops data ----
        tick();
        check("bk.req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        branch_taken = 1'b1; branch_target = 16'h0020;
        tick();
        mem_ack = 1'b0; branch_taken = 1'b0;
        check("bk.no_load",  32'(ir_load),    32'h0);
        check("bk.no_valid", 32'(inst_valid), 32'h0);
        check("bk.mem_req",  32'(mem_req),    32'h1);
        check("bk.mem_addr", 32'(mem_addr),   32'h0020);

        // ---- 6b: reset while in FLUSH ----
        branch_taken = 1'b1; branch_target = 16'h0080;
        tick();
        branch_taken = 1'b0;
        check("t6b.flush_req", 32'(mem_req), 32'h1);
        check("t6b.flush_pc",  32'(pc),      32'h0080);
        RST = 1'b1;
        tick();
        RST = 1'b0; run = 1'b0;
        check_reset("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_fetch_sequencer
